cap_tag_resolver: RTL and testbench



---
 rtl/cap_pkg.sv | 26 ++
 rtl/tag_prio_enc.sv | 28 ++
 rtl/cap_tag_resolver.sv | 123 ++++++++++++
 tb/tb_cap_tag_resolver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cap_pkg.sv
// Shared types for the content-addressable parallel processor array:
// tag-unit op codes, tag-unit FSM states and a width helper.
package cap_pkg;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_SET_ALL      = 3'd1,
        OP_CLEAR_ALL    = 3'd2,
        OP_LOAD_MATCH   = 3'd3,
        OP_AND_MATCH    = 3'd4,
        OP_SELECT_FIRST = 3'd5,
        OP_STEP         = 3'd6,
        OP_COUNT        = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // $clog2 that never returns 0, so a 1-entry structure still gets a 1-bit index.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot of the lowest set bit, its index,
// and the OR of the whole vector.
module tag_prio_enc
    import cap_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int IDX_W   = clog2_safe(N_WORDS)
) (
    input  logic [N_WORDS-1:0] vec,
    output logic [N_WORDS-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Two's-complement trick isolates the lowest set bit; all zero when vec is 0.
    assign onehot = vec & (~vec + N_WORDS'(1));
    assign any    = |vec;

    always_comb begin
        idx = '0;
        for (int i = N_WORDS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cap_tag_resolver.sv
// Tag register and multiple-match resolver: combines match lines into the
// tags, walks responders lowest-first and counts them one chunk per cycle.
module cap_tag_resolver
    import cap_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int CHUNK   = 16,
    parameter int IDX_W   = clog2_safe(N_WORDS),
    parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    // An op transfers on a rising edge where op_valid && op_ready; op_valid
    // is ignored while op_ready is low and no op is queued.
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic [N_WORDS-1:0] match_lines,
    output logic [N_WORDS-1:0] tags,
    output logic               any_tag,
    output logic [IDX_W-1:0]   first_idx,
    output logic [CNT_W-1:0]   tag_count,
    output logic               count_valid,
    output logic               fsm_state
);

    localparam int N_CHUNKS = N_WORDS / CHUNK;
    localparam int PTR_W    = clog2_safe(N_CHUNKS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CHUNKS - 1);

    state_e             state, state_n;
    logic [N_WORDS-1:0] tags_n;
    logic [N_WORDS-1:0] lowest_onehot;
    logic [CNT_W-1:0]   acc, acc_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   tag_count_n;
    logic               count_valid_n;
    logic [CNT_W-1:0]   chunk_sum;

    function automatic logic [CNT_W-1:0] chunk_pop(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    tag_prio_enc #(
        .N_WORDS(N_WORDS),
        .IDX_W  (IDX_W)
    ) u_prio (
        .vec   (tags),
        .onehot(lowest_onehot),
        .idx   (first_idx),
        .any   (any_tag)
    );

    assign chunk_sum = acc + chunk_pop(tags[ptr*CHUNK +: CHUNK]);
    assign fsm_state = state;

    always_comb begin
        state_n       = state;
        tags_n        = tags;
        acc_n         = acc;
        ptr_n         = ptr;
        tag_count_n   = tag_count;
        count_valid_n = 1'b0;
        op_ready      = (state == ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_e'(op_code))
                        OP_SET_ALL:      tags_n = '1;
                        OP_CLEAR_ALL:    tags_n = '0;
                        OP_LOAD_MATCH:   tags_n = match_lines;
                        OP_AND_MATCH:    tags_n = tags & match_lines;
                        // With no tags set the one-hot is zero, so both leave tags at 0.
                        OP_SELECT_FIRST: tags_n = lowest_onehot;
                        OP_STEP:         tags_n = tags & ~lowest_onehot;
                        OP_COUNT: begin
                            state_n = ST_COUNT;
                            acc_n   = '0;
                            ptr_n   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_COUNT: begin
                if (ptr == LAST_PTR) begin
                    tag_count_n   = chunk_sum;
                    count_valid_n = 1'b1;
                    state_n       = ST_IDLE;
                end else begin
                    acc_n = chunk_sum;
                    ptr_n = ptr + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            tags        <= '0;
            acc         <= '0;
            ptr         <= '0;
            tag_count   <= '0;
            count_valid <= 1'b0;
        end else begin
            state       <= state_n;
            tags        <= tags_n;
            acc         <= acc_n;
            ptr         <= ptr_n;
            tag_count   <= tag_count_n;
            count_valid <= count_valid_n;
        end
    end

endmodule

// File: tb/tb_cap_tag_resolver.sv
// Bench for cap_tag_resolver (8 words, 4-bit chunks): directed scenarios plus
// random ops, each cycle compared against a set-level reference model.
module tb_cap_tag_resolver;
    import cap_pkg::*;

    localparam int N   = 8;
    localparam int CH  = 4;
    localparam int K   = N / CH;
    localparam int IW  = 3;
    localparam int CW  = 4;

    logic          CLK;
    logic          RST_N;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [N-1:0]  match_lines;
    logic [N-1:0]  tags;
    logic          any_tag;
    logic [IW-1:0] first_idx;
    logic [CW-1:0] tag_count;
    logic          count_valid;
    logic          fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [N-1:0]  m_tags;
    int            m_busy;
    int            m_pending;
    logic [CW-1:0] m_count;
    logic          m_cv;
    logic [CW-1:0] exp_q[$];

    cap_tag_resolver #(.N_WORDS(N), .CHUNK(CH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .match_lines(match_lines),
        .tags       (tags),
        .any_tag    (any_tag),
        .first_idx  (first_idx),
        .tag_count  (tag_count),
        .count_valid(count_valid),
        .fsm_state  (fsm_state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_tags    = '0;
        m_busy    = 0;
        m_pending = 0;
        m_count   = '0;
        m_cv      = 1'b0;
        exp_q.delete();
    endtask

    task automatic compare_all();
        check("tags",        32'(tags),        32'(m_tags));
        check("any_tag",     32'(any_tag),     32'(m_tags != 0));
        check("first_idx",   32'(first_idx),   32'(lowest_index(m_tags)));
        check("op_ready",    32'(op_ready),    32'(m_busy == 0));
        check("fsm_state",   32'(fsm_state),   32'(m_busy != 0));
        check("count_valid", 32'(count_valid), 32'(m_cv));
        check("tag_count",   32'(tag_count),   32'(m_count));
        if (count_valid) begin
            if (exp_q.size() > 0) check("count_sb", 32'(tag_count), 32'(exp_q.pop_front()));
            else check("cv_unexpected", 32'(count_valid), 32'(0));
        end
    endtask

    // Driver: present one op for one edge, advance the model, then compare.
    task automatic step(input logic v, input logic [2:0] code, input logic [N-1:0] m);
        logic [N-1:0] low;
        op_valid    = v;
        op_code     = code;
        match_lines = m;
        @(posedge CLK);
        m_cv = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_cv    = 1'b1;
                m_count = CW'(m_pending);
            end
        end else if (v) begin
            low = '0;
            if (m_tags != 0) low[lowest_index(m_tags)] = 1'b1;
            case (code)
                3'd1: m_tags = '1;
                3'd2: m_tags = '0;
                3'd3: m_tags = m;
                3'd4: m_tags = m_tags & m;
                3'd5: m_tags = low;
                3'd6: m_tags = m_tags ^ low;
                3'd7: begin
                    m_busy    = K;
                    m_pending = $countones(m_tags);
                    exp_q.push_back(CW'(m_pending));
                end
                default: ;
            endcase
        end
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        RST_N       = 1'b0;
        op_valid    = 1'b0;
        op_code     = '0;
        match_lines = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all();
        RST_N = 1'b1;
    endtask

    int ready_low;

    initial begin
        RST_N       = 1'b1;
        op_valid    = 1'b0;
        op_code     = '0;
        match_lines = '0;
        model_reset();
        #2;

        // 1: reset
        apply_reset();
        check("rst_tags", 32'(tags), 32'h00);
        check("rst_ready", 32'(op_ready), 32'd1);

        // 2: set/and/select
        step(1, OP_SET_ALL, '0);
        step(1, OP_AND_MATCH, 8'hA6);
        check("and_tags", 32'(tags), 32'hA6);
        check("and_first", 32'(first_idx), 32'd1);
        step(1, OP_SELECT_FIRST, 8'hFF);
        check("sel_tags", 32'(tags), 32'h02);

        // 3: STEP walk from 0xA6
        step(1, OP_LOAD_MATCH, 8'hA6);
        for (int i = 0; i < 5; i++) step(1, OP_STEP, 8'($urandom));
        check("step_end", 32'(tags), 32'h00);
        check("step_any", 32'(any_tag), 32'd0);

        // 4: COUNT of all ones, busy ops ignored, op accepted in count_valid cycle
        step(1, OP_SET_ALL, '0);
        step(1, OP_COUNT, '0);
        ready_low = 0;
        for (int i = 0; i < 6 && !count_valid; i++) begin
            if (!op_ready) ready_low++;
            step(1, OP_CLEAR_ALL, '0);
        end
        check("busy_cycles", 32'(ready_low), 32'd2);
        check("count_all", 32'(tag_count), 32'd8);
        check("busy_tags", 32'(tags), 32'hFF);
        step(1, OP_LOAD_MATCH, 8'h3C);
        check("load_in_cv", 32'(tags), 32'h3C);

        // 5: count then reset during a second count
        step(1, OP_LOAD_MATCH, 8'h11);
        step(1, OP_COUNT, '0);
        for (int i = 0; i < K; i++) step(0, OP_NOP, '0);
        check("count_11", 32'(tag_count), 32'd2);
        step(1, OP_COUNT, '0);
        step(0, OP_NOP, '0);
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all();
        step(0, OP_NOP, '0);
        check("abort_count", 32'(tag_count), 32'd0);
        RST_N = 1'b1;
        step(0, OP_NOP, '0);

        // 6: NOP and non-valid ops leave tags
        step(1, OP_LOAD_MATCH, 8'h5A);
        step(1, OP_NOP, 8'hFF);
        check("nop_tags", 32'(tags), 32'h5A);
        step(0, OP_SET_ALL, 8'hFF);
        check("novalid_tags", 32'(tags), 32'h5A);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom));
        end
        for (int i = 0; i < K + 1; i++) step(0, OP_NOP, '0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
